// File: rtl/pad_poller.sv
// pad_poller - two-port SNES-style gamepad poller with atomic button-word commit
// and a one-cycle MMIO read port.
module pad_poller #(
  parameter int HALF_PERIOD = 200,
  parameter int BITS        = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  pad_data,
  output logic        pad_latch,
  output logic        pad_clk,
  output logic        busy,
  output logic        valid,
  input  logic        read_en,
  output logic [31:0] read_data,
  output logic        read_ready
);

  localparam int PW = $clog2(2 * HALF_PERIOD);
  localparam int BW = $clog2(BITS);
  localparam logic [PW-1:0] LATCH_END = PW'(2 * HALF_PERIOD - 1);
  localparam logic [PW-1:0] HALF_END  = PW'(HALF_PERIOD - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_phase;
  logic [BW-1:0]   r_bit_idx;
  logic [1:0]      r_sync1;
  logic [1:0]      r_sync2;
  logic [BITS-1:0] r_shift0;
  logic [BITS-1:0] r_shift1;
  logic [BITS-1:0] r_pad0;
  logic [BITS-1:0] r_pad1;
  logic            r_pad_latch;
  logic            r_pad_clk;
  logic            r_busy;
  logic            r_valid;
  logic [31:0]     r_read_data;
  logic            r_read_ready;
  logic            w_sample;

  always_comb begin
    w_next   = r_state;
    w_sample = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LATCH;
      S_LATCH: if (r_phase == LATCH_END) w_next = S_LOW;
      S_LOW: begin
        if (r_phase == HALF_END) begin
          w_next   = S_HIGH;
          w_sample = 1'b1;
        end
      end
      S_HIGH: begin
        if (r_phase == HALF_END) w_next = (r_bit_idx == BIT_LAST) ? S_DONE : S_LOW;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Pad lines idle high, so the synchronizer resets to 1 to avoid a spurious "pressed".
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
    end else begin
      r_sync1 <= pad_data;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_phase   <= '0;
      r_bit_idx <= '0;
      r_shift0  <= '0;
      r_shift1  <= '0;
      r_pad0    <= '0;
      r_pad1    <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state || r_state == S_IDLE) r_phase <= '0;
      else                                         r_phase <= r_phase + PW'(1);
      if (r_state == S_IDLE && w_next == S_LATCH)     r_bit_idx <= '0;
      else if (r_state == S_HIGH && w_next == S_LOW)  r_bit_idx <= r_bit_idx + BW'(1);
      if (w_sample) begin
        r_shift0[r_bit_idx] <= r_sync2[0];
        r_shift1[r_bit_idx] <= r_sync2[1];
      end
      if (r_state == S_DONE) begin
        r_pad0 <= ~r_shift0;
        r_pad1 <= ~r_shift1;
      end
    end
  end

  // Outputs are registered from the next state so the pad lines move with the state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pad_latch  <= 1'b0;
      r_pad_clk    <= 1'b1;
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
      r_read_data  <= '0;
      r_read_ready <= 1'b0;
    end else begin
      r_pad_latch  <= (w_next == S_LATCH);
      r_pad_clk    <= (w_next != S_LOW);
      r_busy       <= (w_next != S_IDLE);
      r_valid      <= (w_next == S_DONE);
      r_read_ready <= read_en;
      if (read_en) r_read_data <= {16'(r_pad1), 16'(r_pad0)};
    end
  end

  assign pad_latch  = r_pad_latch;
  assign pad_clk    = r_pad_clk;
  assign busy       = r_busy;
  assign valid      = r_valid;
  assign read_data  = r_read_data;
  assign read_ready = r_read_ready;

endmodule

// File: tb/tb_pad_poller.sv
// tb/tb_pad_poller.sv - scoreboard bench for pad_poller with a serial pad model.
module tb_pad_poller;

  localparam int HP   = 4;
  localparam int BITS = 16;
  localparam int POLL_CYCLES = 2 * HP + BITS * 2 * HP + 1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  pad_data;
  logic        pad_latch, pad_clk, busy, valid;
  logic        read_en = 1'b0;
  logic [31:0] read_data;
  logic        read_ready;

  pad_poller #(.HALF_PERIOD(HP), .BITS(BITS)) dut (
    .clk(clk), .resetn(resetn), .start(start), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk), .busy(busy), .valid(valid),
    .read_en(read_en), .read_data(read_data), .read_ready(read_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Pad model: shift register loaded on latch, advanced on each rising pad_clk.
  logic [15:0] btn0 = '0, btn1 = '0;
  bit          connected = 1'b1;
  int          idx = 0;
  always @(posedge pad_latch) idx = 0;
  always @(posedge pad_clk) if (!pad_latch) idx = idx + 1;
  assign pad_data = (!connected || idx >= BITS) ? 2'b11 : ~{btn1[idx], btn0[idx]};

  // Reference: committed button words and expected valid count.
  logic [31:0] model_words = '0;
  int          exp_valids = 0;
  int          valid_total = 0;
  logic [31:0] exp_q[$];

  logic rd_q1 = 1'b0;
  always @(posedge clk or negedge resetn)
    if (!resetn) rd_q1 <= 1'b0; else rd_q1 <= read_en;

  always @(negedge clk) begin
    if (resetn) begin
      if (rd_q1 || read_ready) check("read_ready_timing", {31'b0, read_ready}, {31'b0, rd_q1});
      if (read_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL read_unexpected: got 0x%08h expected no response", read_data);
        end else begin
          check("read_data", read_data, exp_q.pop_front());
        end
      end
    end
  end

  // Poll shape monitor: latch length, falling edges, start-to-valid latency.
  int  cyc = 0, falls = 0, latch_cnt = 0;
  bit  running = 0;
  logic prev_clk = 1'b1, prev_latch = 1'b0;
  always @(negedge clk) begin
    if (!resetn) begin
      running = 0; cyc = 0; falls = 0; latch_cnt = 0;
    end else begin
      if (pad_latch && !prev_latch) begin
        running = 1; cyc = 0; falls = 0; latch_cnt = 0;
      end
      if (running) cyc++;
      if (pad_latch) latch_cnt++;
      if (prev_clk && !pad_clk) falls++;
      if (valid) begin
        valid_total++;
        check("valid_latency", cyc, POLL_CYCLES);
        check("pad_clk_falls", falls, BITS);
        check("latch_cycles", latch_cnt, 2 * HP);
        running = 0;
      end
    end
    prev_clk   = pad_clk;
    prev_latch = pad_latch;
  end

  task automatic do_read();
    @(negedge clk);
    read_en = 1'b1;
    exp_q.push_back(model_words);
    @(negedge clk);
    read_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_poll(input logic [15:0] b0, input logic [15:0] b1, input bit conn,
                         input bit inject, input bit read_in_done);
    bit seen;
    btn0 = b0; btn1 = b1; connected = conn;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("latch_rise_latency", {31'b0, pad_latch}, 32'd1);
    check("busy_after_start", {31'b0, busy}, 32'd1);
    seen = 0;
    for (int t = 2; t < 1000 && !seen; t++) begin
      start = inject && (t == 4 || t == 40);
      @(negedge clk);
      if (valid) seen = 1;
    end
    start = 1'b0;
    if (!seen) begin
      n_checks++; n_errors++;
      $display("FAIL valid_timeout: got no valid expected valid within 1000 cycles");
    end else begin
      exp_valids++;
      if (read_in_done) begin
        read_en = 1'b1;
        exp_q.push_back(model_words);
      end
      if (inject) start = 1'b1;
      @(negedge clk);
      read_en = 1'b0;
      start = 1'b0;
      check("busy_after_done", {31'b0, busy}, 32'd0);
    end
    model_words = conn ? {b1, b0} : 32'h0;
    repeat (3) @(negedge clk);
    check("idle_after_poll", {30'b0, busy, pad_latch}, 32'd0);
    check("valid_count", valid_total, exp_valids);
  endtask

  initial begin
    bit found;
    repeat (2) @(negedge clk);
    check("reset_latch", {31'b0, pad_latch}, 32'd0);
    check("reset_clk", {31'b0, pad_clk}, 32'd1);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_valid", {31'b0, valid}, 32'd0);
    check("reset_read_ready", {31'b0, read_ready}, 32'd0);
    check("reset_read_data", read_data, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    do_read();

    do_poll(16'h0001, 16'h0100, 1'b1, 1'b0, 1'b0);
    do_read();
    do_poll(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    do_read();
    do_poll(16'hA5C3, 16'h3C5A, 1'b1, 1'b1, 1'b0);
    do_read();

    for (int i = 0; i < 4; i++) begin
      do_poll(16'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0), 1'b0, 1'b0);
      do_read();
    end

    do_poll(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
    do_poll(16'h0000, 16'h0001, 1'b1, 1'b0, 1'b1);
    do_read();

    // Reset in the middle of bit 7.
    btn0 = 16'h1234; btn1 = 16'h5678; connected = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int t = 0; t < 1000 && !found; t++) begin
      @(negedge clk);
      if (idx == 7 && !pad_clk) found = 1;
    end
    check("reached_bit7", {31'b0, found}, 32'd1);
    resetn = 1'b0;
    #1;
    check("midreset_latch", {31'b0, pad_latch}, 32'd0);
    check("midreset_clk", {31'b0, pad_clk}, 32'd1);
    check("midreset_busy", {31'b0, busy}, 32'd0);
    model_words = 32'h0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (POLL_CYCLES + 10) @(negedge clk);
    check("midreset_no_valid", valid_total, exp_valids);
    check("midreset_idle", {31'b0, busy}, 32'd0);
    do_read();

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
